// File: rtl/eva_ahb_pkg.sv
// Shared AHB-Lite encodings and the slave FSM state type for the EVA register bank.
package eva_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    localparam logic [1:0] HSIZE_WORD    = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ERR1 = 2'd2,
        ERR2 = 2'd3
    } ahb_slv_st_e;

endpackage

// File: rtl/eva_ahb_regbank.sv
// AHB-Lite slave register bank: NREG-1 RW config words plus one RO status word,
// programmable OKAY wait states and the two-cycle ERROR response.
module eva_ahb_regbank
    import eva_ahb_pkg::*;
#(
    parameter int          NREG     = 16,
    parameter int          WAIT_CYC = 0,
    parameter logic [31:0] BASE     = 32'h0000_0000
) (
    input  logic                 hclk,
    input  logic                 hrest_n,
    input  logic                 hsel,
    input  logic [1:0]           htrans,
    input  logic                 hwrite,
    input  logic [31:0]          haddr,
    input  logic [1:0]           hsize,
    input  logic [31:0]          hwdata,
    input  logic                 hready_in,
    output logic                 hready,
    output logic [1:0]           hresp,
    output logic [31:0]          hrdata,
    input  logic [31:0]          sts_in,
    output logic [32*NREG-1:0]   cfg_q
);

    localparam int              IDXW    = (NREG > 2) ? $clog2(NREG) : 1;
    localparam logic [IDXW-1:0] STS_IDX = IDXW'(NREG - 1);
    localparam logic [31:0]     SPAN    = 32'(NREG * 4);
    localparam logic [3:0]      WLOAD   = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

    logic [31:0]     r_regs [0:NREG-2];
    ahb_slv_st_e     r_st, w_st_nxt;
    logic [3:0]      r_cnt, w_cnt_nxt;
    logic            r_pend, r_pwrite;
    logic [IDXW-1:0] r_pidx;
    logic [31:0]     r_rdata;

    logic            w_hready;
    logic [1:0]      w_hresp;
    logic [31:0]     w_off;
    logic [IDXW-1:0] w_idx;
    logic            w_acc, w_err, w_commit;
    logic [31:0]     w_rreg, w_rnext;

    // hready/hresp decode straight from the state flop, so they are glitch-free.
    assign w_hready = (r_st == IDLE) || (r_st == ERR2);
    assign w_hresp  = ((r_st == ERR1) || (r_st == ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign hready   = w_hready;
    assign hresp    = w_hresp;
    assign hrdata   = r_rdata;

    // Offset wraps for haddr < BASE; the range check then rejects it.
    assign w_off    = haddr - BASE;
    assign w_idx    = w_off[IDXW+1:2];
    assign w_acc    = hsel & hready_in & w_hready &
                      ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
    assign w_err    = (w_off >= SPAN) || (haddr[1:0] != 2'b00) ||
                      (hsize != HSIZE_WORD) || (hwrite && (w_idx == STS_IDX));
    assign w_commit = r_pend & r_pwrite & w_hready & (w_hresp == HRESP_OKAY);

    // Read mux over the RW words; the status index is handled separately.
    always_comb begin
        w_rreg = '0;
        for (int i = 0; i < NREG - 1; i++) begin
            if (w_idx == IDXW'(i)) w_rreg = r_regs[i];
        end
    end

    // Forward write data when a same-index write commits on the accept edge.
    assign w_rnext = (w_idx == STS_IDX)                  ? sts_in :
                     (w_commit && (r_pidx == w_idx))     ? hwdata : w_rreg;

    // Next-state and wait-counter logic; ERR2 accepts a new address like IDLE.
    always_comb begin
        w_st_nxt  = r_st;
        w_cnt_nxt = r_cnt;
        case (r_st)
            IDLE, ERR2: begin
                w_st_nxt = IDLE;
                if (w_acc) begin
                    if (w_err) begin
                        w_st_nxt = ERR1;
                    end else if (WAIT_CYC > 0) begin
                        w_st_nxt  = WAIT;
                        w_cnt_nxt = WLOAD;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) w_st_nxt = IDLE;
                else               w_cnt_nxt = r_cnt - 4'd1;
            end
            ERR1:    w_st_nxt = ERR2;
            default: w_st_nxt = IDLE;
        endcase
    end

    // State and wait-counter registers.
    always_ff @(posedge hclk or negedge hrest_n) begin
        if (!hrest_n) begin
            r_st  <= IDLE;
            r_cnt <= 4'd0;
        end else begin
            r_st  <= w_st_nxt;
            r_cnt <= w_cnt_nxt;
        end
    end

    // Pending data-phase tracking; erroneous writes are never marked as writes.
    always_ff @(posedge hclk or negedge hrest_n) begin
        if (!hrest_n) begin
            r_pend   <= 1'b0;
            r_pwrite <= 1'b0;
            r_pidx   <= '0;
        end else if (w_acc) begin
            r_pend   <= 1'b1;
            r_pwrite <= hwrite & ~w_err;
            r_pidx   <= w_idx;
        end else if (w_hready) begin
            r_pend   <= 1'b0;
            r_pwrite <= 1'b0;
        end
    end

    // Read data captured at accept and held through wait states, else zero.
    always_ff @(posedge hclk or negedge hrest_n) begin
        if (!hrest_n) begin
            r_rdata <= '0;
        end else if (w_acc) begin
            r_rdata <= (!hwrite && !w_err) ? w_rnext : 32'h0;
        end else if (w_hready) begin
            r_rdata <= '0;
        end
    end

    // RW register array, written when an OKAY write data phase completes.
    always_ff @(posedge hclk or negedge hrest_n) begin
        if (!hrest_n) begin
            for (int i = 0; i < NREG - 1; i++) r_regs[i] <= '0;
        end else begin
            for (int i = 0; i < NREG - 1; i++) begin
                if (w_commit && (r_pidx == IDXW'(i))) r_regs[i] <= hwdata;
            end
        end
    end

    for (genvar g = 0; g < NREG - 1; g++) begin : g_cfg
        assign cfg_q[32*g +: 32] = r_regs[g];
    end
    assign cfg_q[32*(NREG-1) +: 32] = sts_in;

endmodule

// File: tb/tb_eva_ahb_regbank.sv
// Self-checking bench: two bank instances (0 and 3 wait states) against an array model.
module tb_eva_ahb_regbank;
    import eva_ahb_pkg::*;

    localparam int          NREG = 16;
    localparam logic [31:0] BASE = 32'h4000_0000;

    logic               hclk = 1'b0;
    logic               hrest_n;
    logic               hsel0, hsel3;
    logic [1:0]         htrans;
    logic               hwrite;
    logic [31:0]        haddr;
    logic [1:0]         hsize;
    logic [31:0]        hwdata;
    logic [31:0]        sts_in;
    logic               hready0, hready3;
    logic [1:0]         hresp0, hresp3;
    logic [31:0]        hrdata0, hrdata3;
    logic [32*NREG-1:0] cfg0, cfg3;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] m0 [NREG];
    logic [31:0] m3 [NREG];

    always #5 hclk = ~hclk;

    eva_ahb_regbank #(.NREG(NREG), .WAIT_CYC(0), .BASE(BASE)) u_w0 (
        .hclk(hclk), .hrest_n(hrest_n), .hsel(hsel0), .htrans(htrans), .hwrite(hwrite),
        .haddr(haddr), .hsize(hsize), .hwdata(hwdata), .hready_in(hready0),
        .hready(hready0), .hresp(hresp0), .hrdata(hrdata0), .sts_in(sts_in), .cfg_q(cfg0));

    eva_ahb_regbank #(.NREG(NREG), .WAIT_CYC(3), .BASE(BASE)) u_w3 (
        .hclk(hclk), .hrest_n(hrest_n), .hsel(hsel3), .htrans(htrans), .hwrite(hwrite),
        .haddr(haddr), .hsize(hsize), .hwdata(hwdata), .hready_in(hready3),
        .hready(hready3), .hresp(hresp3), .hrdata(hrdata3), .sts_in(sts_in), .cfg_q(cfg3));

    function automatic logic rdy(input int inst);
        return (inst == 0) ? hready0 : hready3;
    endfunction

    function automatic logic [1:0] rsp(input int inst);
        return (inst == 0) ? hresp0 : hresp3;
    endfunction

    function automatic logic [31:0] rdat(input int inst);
        return (inst == 0) ? hrdata0 : hrdata3;
    endfunction

    function automatic logic [31:0] mread(input int inst, input int idx);
        return (inst == 0) ? m0[idx] : m3[idx];
    endfunction

    function automatic logic [31:0] cfg_word(input int inst, input int idx);
        return (inst == 0) ? cfg0[32*idx +: 32] : cfg3[32*idx +: 32];
    endfunction

    // Number of RW words whose cfg_q image disagrees with the model.
    function automatic int cfg_bad(input int inst);
        int n = 0;
        for (int i = 0; i < NREG - 1; i++)
            if (cfg_word(inst, i) !== mread(inst, i)) n++;
        return n;
    endfunction

    task automatic mwrite(input int inst, input int idx, input logic [31:0] v);
        if (inst == 0) m0[idx] = v; else m3[idx] = v;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NREG; i++) begin m0[i] = '0; m3[i] = '0; end
    endtask

    task automatic drive_idle();
        hsel0 = 1'b0; hsel3 = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0;
        haddr = '0; hsize = HSIZE_WORD;
    endtask

    // Single transfer; entered and left at 1 time unit after a rising edge.
    task automatic xfer(input int inst, input bit wr, input logic [31:0] addr,
                        input logic [1:0] size, input logic [31:0] wd,
                        output int lowc, output logic [1:0] rlow, output logic [1:0] rhi,
                        output logic [31:0] rd, output bit tmo);
        bit done = 1'b0;
        lowc = 0; rlow = 2'b00; rhi = 2'b00; rd = '0; tmo = 1'b0;
        if (inst == 0) hsel0 = 1'b1; else hsel3 = 1'b1;
        htrans = HTRANS_NONSEQ; hwrite = wr; haddr = addr; hsize = size;
        @(posedge hclk); #1;
        drive_idle();
        hwdata = wd;
        for (int k = 0; k < 40 && !done; k++) begin
            if (rdy(inst) === 1'b1) begin
                rhi = rsp(inst); rd = rdat(inst); done = 1'b1;
            end else begin
                lowc++; rlow = rlow | rsp(inst);
                @(posedge hclk); #1;
            end
        end
        if (!done) tmo = 1'b1;
        @(posedge hclk); #1;
    endtask

    task automatic test_reset();
        hrest_n = 1'b0; sts_in = '0; hwdata = '0;
        drive_idle();
        model_clear();
        repeat (3) @(posedge hclk);
        #1;
        for (int inst = 0; inst < 2; inst++) begin
            n_total++; if (rdy(inst) !== 1'b1) $display("FAIL reset_hready%0d: got %b want 1", inst, rdy(inst)); else n_pass++;
            n_total++; if (rsp(inst) !== 2'b00) $display("FAIL reset_hresp%0d: got %b want 00", inst, rsp(inst)); else n_pass++;
            n_total++; if (rdat(inst) !== 32'h0) $display("FAIL reset_hrdata%0d: got %h want 0", inst, rdat(inst)); else n_pass++;
        end
        n_total++; if (cfg0 !== '0 || cfg3 !== '0) $display("FAIL reset_cfg: got nonzero image want all 0"); else n_pass++;
        hrest_n = 1'b1;
        @(posedge hclk); #1;
    endtask

    task automatic test_write_read();
        int lowc; logic [1:0] rl, rh; logic [31:0] rd; bit tmo;
        xfer(0, 1'b1, BASE + 32'h4, HSIZE_WORD, 32'hDEAD_BEEF, lowc, rl, rh, rd, tmo);
        mwrite(0, 1, 32'hDEAD_BEEF);
        n_total++; if (lowc !== 0 || tmo) $display("FAIL wr_wait: got %0d low cycles want 0", lowc); else n_pass++;
        n_total++; if (rh !== HRESP_OKAY) $display("FAIL wr_resp: got %b want 00", rh); else n_pass++;
        xfer(0, 1'b0, BASE + 32'h4, HSIZE_WORD, 32'h0, lowc, rl, rh, rd, tmo);
        n_total++; if (lowc !== 0 || tmo) $display("FAIL rd_wait: got %0d low cycles want 0", lowc); else n_pass++;
        n_total++; if (rd !== 32'hDEAD_BEEF || rh !== HRESP_OKAY) $display("FAIL rd_data: got %h/%b want deadbeef/00", rd, rh); else n_pass++;
        n_total++; if (cfg0[63:32] !== 32'hDEAD_BEEF) $display("FAIL cfg_word1: got %h want deadbeef", cfg0[63:32]); else n_pass++;
        n_total++; if (hrdata0 !== 32'h0) $display("FAIL rd_idle: got %h want 0", hrdata0); else n_pass++;
    endtask

    task automatic test_wait();
        int lowc; logic [1:0] rl, rh; logic [31:0] rd; bit tmo;
        hsel3 = 1'b1; htrans = HTRANS_BUSY; haddr = BASE;
        @(posedge hclk); #1;
        drive_idle();
        n_total++; if (hready3 !== 1'b1) $display("FAIL busy_ignored: got hready %b want 1", hready3); else n_pass++;
        xfer(1, 1'b0, BASE, HSIZE_WORD, 32'h0, lowc, rl, rh, rd, tmo);
        n_total++; if (lowc !== 3 || tmo) $display("FAIL wait_cycles: got %0d want 3", lowc); else n_pass++;
        n_total++; if (rl !== HRESP_OKAY || rh !== HRESP_OKAY) $display("FAIL wait_resp: got %b/%b want 00/00", rl, rh); else n_pass++;
        n_total++; if (rd !== mread(1, 0)) $display("FAIL wait_rdata: got %h want %h", rd, mread(1, 0)); else n_pass++;
    endtask

    task automatic test_errors();
        int lowc; logic [1:0] rl, rh; logic [31:0] rd; bit tmo;
        logic [31:0] ea [5];
        logic [1:0]  es [5];
        bit          ew [5];
        ea[0] = BASE + 32'(NREG*4);     es[0] = HSIZE_WORD; ew[0] = 1'b1;
        ea[1] = BASE + 32'h2;           es[1] = HSIZE_WORD; ew[1] = 1'b1;
        ea[2] = BASE;                   es[2] = 2'b00;      ew[2] = 1'b1;
        ea[3] = BASE + 32'((NREG-1)*4); es[3] = HSIZE_WORD; ew[3] = 1'b1;
        ea[4] = BASE - 32'h4;           es[4] = HSIZE_WORD; ew[4] = 1'b0;
        for (int inst = 0; inst < 2; inst++) begin
            for (int c = 0; c < 5; c++) begin
                xfer(inst, ew[c], ea[c], es[c], 32'hFFFF_FFFF, lowc, rl, rh, rd, tmo);
                n_total++; if (lowc !== 1 || tmo) $display("FAIL err%0d_%0d_low: got %0d want 1", inst, c, lowc); else n_pass++;
                n_total++; if (rl !== HRESP_ERROR || rh !== HRESP_ERROR) $display("FAIL err%0d_%0d_resp: got %b/%b want 01/01", inst, c, rl, rh); else n_pass++;
                n_total++; if (rd !== 32'h0 || cfg_bad(inst) !== 0) $display("FAIL err%0d_%0d_state: rdata %h, %0d regs changed, want 0/0", inst, c, rd, cfg_bad(inst)); else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back();
        int lowc; logic [1:0] rl, rh; logic [31:0] rd; bit tmo;
        logic [31:0] bd [4];
        bit stall = 1'b0;
        xfer(0, 1'b1, BASE + 32'h8, HSIZE_WORD, 32'h5555_5555, lowc, rl, rh, rd, tmo);
        mwrite(0, 2, 32'h5555_5555);
        hsel0 = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b1; haddr = BASE + 32'h8; hsize = HSIZE_WORD;
        @(posedge hclk); #1;
        n_total++; if (hready0 !== 1'b1) $display("FAIL b2b_wr_ready: got %b want 1", hready0); else n_pass++;
        hwrite = 1'b0; hwdata = 32'h0000_1234;
        @(posedge hclk); #1;
        drive_idle();
        mwrite(0, 2, 32'h0000_1234);
        n_total++; if (hrdata0 !== 32'h0000_1234 || hresp0 !== HRESP_OKAY) $display("FAIL b2b_fwd: got %h/%b want 00001234/00", hrdata0, hresp0); else n_pass++;
        n_total++; if (cfg_bad(0) !== 0) $display("FAIL b2b_cfg: got %0d bad regs want 0", cfg_bad(0)); else n_pass++;
        @(posedge hclk); #1;
        n_total++; if (hrdata0 !== 32'h0) $display("FAIL b2b_idle: got %h want 0", hrdata0); else n_pass++;
        // Four pipelined writes then four pipelined reads, one beat per cycle.
        for (int j = 0; j < 4; j++) begin bd[j] = $urandom; mwrite(0, 4 + j, bd[j]); end
        for (int j = 0; j < 9; j++) begin
            hwdata = (j >= 1 && j <= 4) ? bd[j-1] : 32'h0;
            if (j < 8) begin
                hsel0 = 1'b1; hsize = HSIZE_WORD; hwrite = (j < 4);
                htrans = (j == 0 || j == 4) ? HTRANS_NONSEQ : HTRANS_SEQ;
                haddr = BASE + 32'(16 + 4*(j % 4));
            end else begin
                drive_idle();
            end
            @(posedge hclk); #1;
            if (hready0 !== 1'b1) stall = 1'b1;
            if (j >= 4 && j < 8) begin
                n_total++; if (hrdata0 !== mread(0, j)) $display("FAIL burst_rd%0d: got %h want %h", j - 4, hrdata0, mread(0, j)); else n_pass++;
            end
        end
        n_total++; if (stall) $display("FAIL burst_stall: got a low hready want none"); else n_pass++;
        n_total++; if (cfg_bad(0) !== 0) $display("FAIL burst_cfg: got %0d bad regs want 0", cfg_bad(0)); else n_pass++;
    endtask

    task automatic test_status();
        int lowc; logic [1:0] rl, rh; logic [31:0] rd; bit tmo;
        sts_in = 32'hA5A5_0001;
        xfer(0, 1'b0, BASE + 32'((NREG-1)*4), HSIZE_WORD, 32'h0, lowc, rl, rh, rd, tmo);
        n_total++; if (rd !== 32'hA5A5_0001 || rh !== HRESP_OKAY || lowc !== 0 || tmo) $display("FAIL status_rd: got %h/%b/%0d want a5a50001/00/0", rd, rh, lowc); else n_pass++;
    endtask

    task automatic test_random();
        int lowc; logic [1:0] rl, rh; logic [31:0] rd; bit tmo;
        int inst, idx, elow;
        bit wr, err;
        logic [31:0] addr, off, wd, erd;
        logic [1:0] size, eresp;
        for (int it = 0; it < 40; it++) begin
            inst = $urandom_range(0, 1);
            wr   = 1'($urandom_range(0, 1));
            wd   = $urandom;
            sts_in = $urandom;
            case ($urandom_range(0, 9))
                0:       addr = BASE + 32'(NREG*4) + 32'($urandom_range(0, 15) * 4);
                1:       addr = BASE + 32'($urandom_range(0, NREG-1) * 4) + 32'($urandom_range(1, 3));
                2:       addr = BASE - 32'($urandom_range(1, 8) * 4);
                default: addr = BASE + 32'($urandom_range(0, NREG-1) * 4);
            endcase
            size = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : HSIZE_WORD;
            off  = addr - BASE;
            idx  = int'(off >> 2);
            err  = (off >= 32'(NREG*4)) || (addr[1:0] != 2'b00) || (size != HSIZE_WORD) ||
                   (wr && idx == NREG - 1);
            elow  = err ? 1 : ((inst == 0) ? 0 : 3);
            eresp = err ? HRESP_ERROR : HRESP_OKAY;
            erd   = (!wr && !err) ? ((idx == NREG - 1) ? sts_in : mread(inst, idx)) : 32'h0;
            xfer(inst, wr, addr, size, wd, lowc, rl, rh, rd, tmo);
            if (wr && !err) mwrite(inst, idx, wd);
            n_total++; if (lowc !== elow || tmo) $display("FAIL rnd%0d_low: got %0d want %0d", it, lowc, elow); else n_pass++;
            n_total++; if (rh !== eresp) $display("FAIL rnd%0d_resp: got %b want %b", it, rh, eresp); else n_pass++;
            n_total++; if (elow > 0 && rl !== eresp) $display("FAIL rnd%0d_lowresp: got %b want %b", it, rl, eresp); else n_pass++;
            n_total++; if (rd !== erd) $display("FAIL rnd%0d_rdata: got %h want %h", it, rd, erd); else n_pass++;
            n_total++; if (cfg_bad(inst) !== 0) $display("FAIL rnd%0d_cfg: got %0d bad regs want 0", it, cfg_bad(inst)); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        hsel3 = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b1; haddr = BASE + 32'hC; hsize = HSIZE_WORD;
        @(posedge hclk); #1;
        drive_idle();
        hwdata = 32'h7777_7777;
        @(posedge hclk); #1;
        n_total++; if (hready3 !== 1'b0) $display("FAIL rst_mid_inwait: got hready %b want 0", hready3); else n_pass++;
        #2 hrest_n = 1'b0;
        model_clear();
        #1;
        n_total++; if (hready3 !== 1'b1 || hresp3 !== HRESP_OKAY) $display("FAIL rst_mid_bus: got %b/%b want 1/00", hready3, hresp3); else n_pass++;
        n_total++; if (cfg3[32*3 +: 32] !== 32'h0 || hrdata3 !== 32'h0) $display("FAIL rst_mid_reg3: got %h/%h want 0/0", cfg3[32*3 +: 32], hrdata3); else n_pass++;
        @(posedge hclk); #1;
        hrest_n = 1'b1;
        repeat (4) @(posedge hclk);
        #1;
        n_total++; if (hready3 !== 1'b1 || cfg_bad(1) !== 0 || cfg_bad(0) !== 0) $display("FAIL rst_mid_after: hready %b, bad %0d/%0d want 1, 0/0", hready3, cfg_bad(0), cfg_bad(1)); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_wait();
        test_errors();
        test_back_to_back();
        test_status();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
